// File: rtl/uart_tx.sv
// UART transmitter: word FIFO feeding a start/data/stop serializer.
// Serial line and bit strobe are registered; tx_rdy is a registered not-full flag.
module uart_tx #(
  parameter int DATA_BITS    = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_din,
  input  logic                 tx_vin,
  output logic                 tx_rdy,
  output logic                 tx_dout,
  output logic                 tx_vout,
  output logic                 tx_busy
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [OW-1:0]        occ, occ_d;
  logic                 rdy_q;
  logic                 push, pop, empty;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [BW-1:0]        bit_idx, bit_d;
  logic [DATA_BITS-1:0] shreg, shreg_d, shifted;
  logic                 dout_q, dout_d;
  logic                 vout_q, vout_d;
  logic                 load;

  assign empty   = (occ == '0);
  assign push    = tx_vin && rdy_q;
  assign shifted = shreg >> 1;

  always_comb begin
    occ_d = occ;
    case ({push, pop})
      2'b10:   occ_d = occ + OW'(1);
      2'b01:   occ_d = occ - OW'(1);
      default: occ_d = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      rdy_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ   <= occ_d;
      rdy_q <= (occ_d != OCC_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_din;
  end

  // load: pop the head word and emit its start bit next cycle
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    shreg_d = shreg;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        dout_d = 1'b1;
        if (!empty) load = 1'b1;
      end
      START: begin
        if (cnt == '0) begin
          state_d = DATA;
          bit_d   = '0;
          cnt_d   = CNT_LAST;
          dout_d  = shreg[0];
          vout_d  = 1'b1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_d  = CNT_LAST;
          vout_d = 1'b1;
          if (bit_idx == BIT_LAST) begin
            state_d = STOP;
            dout_d  = 1'b1;
          end else begin
            bit_d   = bit_idx + BW'(1);
            shreg_d = shifted;
            dout_d  = shifted[0];
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (!empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            dout_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      shreg_d = mem[rd_ptr];
      state_d = START;
      cnt_d   = CNT_LAST;
      dout_d  = 1'b0;
      vout_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      dout_q  <= 1'b1;
      vout_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shreg   <= shreg_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
    end
  end

  assign tx_rdy  = rdy_q;
  assign tx_dout = dout_q;
  assign tx_vout = vout_q;
  assign tx_busy = (state != IDLE) || !empty;

endmodule
